alu_regfile_pipe: RTL and testbench
===================================

// Module: alu_regfile_pipe
// PURPOSE
//  Parametrised successor to the single-cycle ALU-plus-output-register datapath.
//  Adds a DEPTH-entry register file, a 2-stage valid/ready pipeline, status flags and an external load port.
//  Each op reads two registers, computes A op B and writes the result back to register rd.
//  It also presents the result and flags downstream.
//  Sits between an instruction sequencer (upstream) and a result consumer (downstream).
// PARAMETERS
//  WIDTH     32  datapath width in bits (>=4)
//  DEPTH     8   register-file entries (power of 2, >=2); AW = $clog2(DEPTH)
//  ZERO_REG  1   1: register 0 always reads 0 and ignores writes; 0: ordinary register
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      op request valid
//  in_ready   out  1      block can accept the op this cycle
//  alu_op     in   3      operation select (encoding below)
//  rs_a       in   AW     source register A
//  rs_b       in   AW     source register B
//  rd         in   AW     destination register
//  ld_en      in   1      external register load strobe
//  ld_addr    in   AW     load address
//  ld_data    in   WIDTH  load value
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_data   out  WIDTH  result
//  out_rd     out  AW     destination of the result
//  out_flags  out  4      {N,Z,C,V}
// BEHAVIOUR
//  alu_op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLT (signed, result 0/1), 110 SLL, 111 SRL.
//   Shift amount = B[AW_S-1:0], where AW_S = $clog2(WIDTH).
//  Flags: N = res[WIDTH-1]; Z = (res==0).
//   C: ADD carry-out; SUB 1 when A<B unsigned (borrow); 0 for all other ops.
//   V: signed overflow for ADD/SUB; 0 for all other ops.
//  Pipeline:
//   S1 = operands, op and rd registered.
//   S2 = ALU result, flags and rd registered, which are the outputs.
//   s1_adv = s1_valid & (~s2_valid | out_ready)
//   in_ready = ~rst & (~s1_valid | s1_adv)   (combinational)
//  Op accepted on edge k (in_valid & in_ready) -> out_valid high after edge k+1.
//   Throughput: 1 op/cycle when out_ready is held high.
//  Writeback: on the s1_adv edge, the ALU result is written to regfile[rd] in the same edge it enters S2.
//  Bypass: a source read in the accept cycle whose address matches that cycle's writeback rd returns the writeback data.
//   The next op therefore sees the previous result with no stall.
//   Writeback-data bypass has priority over ld_data bypass.
//  Load port: ld_en writes ld_data to regfile[ld_addr] on any cycle, independent of the handshake.
//   Same address as a writeback on the same edge: writeback wins.
//   Matching accept-cycle reads also bypass ld_data.
//  ZERO_REG=1: reads of address 0 return 0, including via bypass; writes to address 0 are dropped.
//   The result is still output with out_rd=0.
//  Backpressure: out_valid & ~out_ready holds out_data, out_rd and out_flags stable.
//   S1 holds; in_ready falls once S1 is also occupied. No op is lost or duplicated.
//  Reset (sync): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_rd=0, out_flags=0, all regfile entries=0.
//   in_ready=0 during the rst cycle.
//   Reset mid-operation discards in-flight ops with no writeback on that edge; ld_en is also ignored while rst is high.
// STRUCTURE
//  Shared package alu_pkg: ALU_ADD..ALU_SRL localparams, flag bit indices (FLG_N=3, FLG_Z=2, FLG_C=1, FLG_V=0).
//  Sub-module alu_core #(WIDTH): combinational (a, b, op) -> (res, flags); instantiated once, between S1 and S2.
//  Regfile, bypass muxes and handshake control stay in alu_regfile_pipe.
// TESTING
//  1. Load and add: ld r1=5, ld r2=7; ADD rd=3 rs 1,2 -> out_data=12, flags=0000; r3 reads 12 later.
//  2. Back-to-back dependency: ADD r3=r1+r2 then SUB r4=r3-r1 on consecutive cycles -> 12 then 7, no stall.
//  3. Flags at WIDTH=32:
//     ADD 0x7FFFFFFF+1 -> 0x80000000, N=1, V=1.
//     SUB 3-5 -> 0xFFFFFFFE, N=1, C=1.
//     SUB 4-4 -> Z=1.
//     ADD 0xFFFFFFFF+1 -> 0, Z=1, C=1.
//  4. Backpressure: out_ready=0 for 4 cycles with 3 ops offered -> in_ready falls after 2 accepted.
//     Outputs stay stable; on release the results emerge in order, with no loss.
//  5. ZERO_REG: ld r0=9, then ADD r0=r0+r0 -> out_data=0, r0 still reads 0. Shifts: SLL 1<<31 = 0x80000000; SRL by 32 uses amount 0.
//  6. Reset mid-op: assert rst with both stages full -> next cycle out_valid=0, all regs 0, and the pending op's rd is not written.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU / register-file pipeline.
//   ALU_* : 3-bit operation encodings driven on alu_op.
//   FLG_* : bit positions inside the 4-bit {N,Z,C,V} flag vector.
package alu_pkg;

  typedef logic [2:0] alu_op_t;

  localparam alu_op_t ALU_ADD = 3'b000;
  localparam alu_op_t ALU_SUB = 3'b001;
  localparam alu_op_t ALU_AND = 3'b010;
  localparam alu_op_t ALU_OR  = 3'b011;
  localparam alu_op_t ALU_XOR = 3'b100;
  localparam alu_op_t ALU_SLT = 3'b101;
  localparam alu_op_t ALU_SLL = 3'b110;
  localparam alu_op_t ALU_SRL = 3'b111;

  localparam int FLG_N = 3;
  localparam int FLG_Z = 2;
  localparam int FLG_C = 1;
  localparam int FLG_V = 0;

endpackage

// File: rtl/alu_core.sv
// alu_core: purely combinational ALU.
//   a, b  : operands (WIDTH bits)
//   op    : operation select (alu_pkg::ALU_*)
//   res   : result
//   flags : {N,Z,C,V}; C and V are only meaningful for ADD/SUB, 0 otherwise.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_op_t          op,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int SW  = $clog2(WIDTH);
  localparam int MSB = WIDTH - 1;

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SW-1:0]    shamt;
  logic             add_ovf;
  logic             sub_ovf;
  logic             slt;
  logic             carry;
  logic             ovf;

  // Extra top bit holds carry-out for ADD and the borrow (A<B unsigned) for SUB.
  assign sum_ext  = {1'b0, a} + {1'b0, b};
  assign diff_ext = {1'b0, a} - {1'b0, b};
  assign shamt    = b[SW-1:0];

  // Signed overflow: operands' signs make the true result unrepresentable.
  assign add_ovf = (a[MSB] == b[MSB]) && (sum_ext[MSB] != a[MSB]);
  assign sub_ovf = (a[MSB] != b[MSB]) && (diff_ext[MSB] != a[MSB]);
  assign slt     = $signed(a) < $signed(b);

  always_comb begin
    res   = '0;
    carry = 1'b0;
    ovf   = 1'b0;
    case (op)
      ALU_ADD: begin
        res   = sum_ext[WIDTH-1:0];
        carry = sum_ext[WIDTH];
        ovf   = add_ovf;
      end
      ALU_SUB: begin
        res   = diff_ext[WIDTH-1:0];
        carry = diff_ext[WIDTH];
        ovf   = sub_ovf;
      end
      ALU_AND: res = a & b;
      ALU_OR:  res = a | b;
      ALU_XOR: res = a ^ b;
      ALU_SLT: res = {{(WIDTH-1){1'b0}}, slt};
      ALU_SLL: res = a << shamt;
      ALU_SRL: res = a >> shamt;
      default: res = '0;
    endcase

    flags        = '0;
    flags[FLG_N] = res[MSB];
    flags[FLG_Z] = (res == '0);
    flags[FLG_C] = carry;
    flags[FLG_V] = ovf;
  end

endmodule

// File: rtl/alu_regfile_pipe.sv
// alu_regfile_pipe: register file + 2-stage valid/ready ALU pipeline.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : op request handshake (alu_op, rs_a, rs_b, rd)
//   ld_en/ld_addr/ld_data : external register load, independent of the handshake
//   out_valid/out_ready : result handshake (out_data, out_rd, out_flags {N,Z,C,V})
// Stage 1 holds the operands read at accept time; stage 2 holds the ALU result,
// which is written back to the register file on the same edge it enters stage 2.
module alu_regfile_pipe
  import alu_pkg::*;
#(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 8,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_t          alu_op,
  input  logic [AW-1:0]    rs_a,
  input  logic [AW-1:0]    rs_b,
  input  logic [AW-1:0]    rd,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [AW-1:0]    out_rd,
  output logic [3:0]       out_flags
);

  logic [WIDTH-1:0] rf_q [DEPTH];

  logic             s1_valid_reg;
  logic [WIDTH-1:0] s1_a_reg;
  logic [WIDTH-1:0] s1_b_reg;
  alu_op_t          s1_op_reg;
  logic [AW-1:0]    s1_rd_reg;

  logic             s2_valid_reg;
  logic [WIDTH-1:0] s2_data_reg;
  logic [AW-1:0]    s2_rd_reg;
  logic [3:0]       s2_flags_reg;

  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flags;
  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic             s1_adv;
  logic             accept;

  assign s1_adv   = s1_valid_reg & (~s2_valid_reg | out_ready);
  assign in_ready = ~rst & (~s1_valid_reg | s1_adv);
  assign accept   = in_valid & in_ready;

  alu_core #(.WIDTH(WIDTH)) u_alu (
    .a     (s1_a_reg),
    .b     (s1_b_reg),
    .op    (s1_op_reg),
    .res   (alu_res),
    .flags (alu_flags)
  );

  // Register file. Entry 0 has no storage when it is hardwired to zero.
  // On a same-edge collision the pipeline writeback beats the load port.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_rf
    if (ZERO_REG != 0 && gi == 0) begin : g_zero
      assign rf_q[gi] = '0;
    end else begin : g_entry
      logic [WIDTH-1:0] entry_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          entry_reg <= '0;
        end else if (s1_adv && s1_rd_reg == AW'(gi)) begin
          entry_reg <= alu_res;
        end else if (ld_en && ld_addr == AW'(gi)) begin
          entry_reg <= ld_data;
        end
      end
      assign rf_q[gi] = entry_reg;
    end
  end

  // Source read with forwarding of this cycle's writes, so a dependent op
  // issued right behind its producer sees the fresh value without a stall.
  function automatic logic [WIDTH-1:0] read_src(
    input logic [AW-1:0]    addr,
    input logic [WIDTH-1:0] rf_val,
    input logic             wb_en,
    input logic [AW-1:0]    wb_rd,
    input logic [WIDTH-1:0] wb_data,
    input logic             ld_we,
    input logic [AW-1:0]    ld_a,
    input logic [WIDTH-1:0] ld_d
  );
    if (ZERO_REG != 0 && addr == '0) return '0;
    if (wb_en && wb_rd == addr)      return wb_data;
    if (ld_we && ld_a == addr)       return ld_d;
    return rf_val;
  endfunction

  assign src_a = read_src(rs_a, rf_q[rs_a], s1_adv, s1_rd_reg, alu_res,
                          ld_en, ld_addr, ld_data);
  assign src_b = read_src(rs_b, rf_q[rs_b], s1_adv, s1_rd_reg, alu_res,
                          ld_en, ld_addr, ld_data);

  // Stage 1: operands captured at accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_op_reg    <= ALU_ADD;
      s1_rd_reg    <= '0;
    end else if (accept) begin
      s1_valid_reg <= 1'b1;
      s1_a_reg     <= src_a;
      s1_b_reg     <= src_b;
      s1_op_reg    <= alu_op;
      s1_rd_reg    <= rd;
    end else if (s1_adv) begin
      s1_valid_reg <= 1'b0;
    end
  end

  // Stage 2: result and flags; held while downstream stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_data_reg  <= '0;
      s2_rd_reg    <= '0;
      s2_flags_reg <= '0;
    end else if (s1_adv) begin
      s2_valid_reg <= 1'b1;
      s2_data_reg  <= alu_res;
      s2_rd_reg    <= s1_rd_reg;
      s2_flags_reg <= alu_flags;
    end else if (out_ready) begin
      s2_valid_reg <= 1'b0;
    end
  end

  assign out_valid = s2_valid_reg;
  assign out_data  = s2_data_reg;
  assign out_rd    = s2_rd_reg;
  assign out_flags = s2_flags_reg;

endmodule

// File: tb/tb_alu_regfile_pipe.sv
// tb_alu_regfile_pipe: scoreboard bench. The driver pushes the expected result
// of every accepted op; an independent monitor pops and compares each output
// beat and checks that stalled outputs stay stable.
module tb_alu_regfile_pipe;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  typedef struct packed {
    logic [31:0] d;
    logic [2:0]  rd;
    logic [3:0]  f;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       alu_op;
  logic [AW-1:0]    rs_a;
  logic [AW-1:0]    rs_b;
  logic [AW-1:0]    rd;
  logic             ld_en;
  logic [AW-1:0]    ld_addr;
  logic [WIDTH-1:0] ld_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [AW-1:0]    out_rd;
  logic [3:0]       out_flags;

  always #5 clk = ~clk;

  alu_regfile_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ZERO_REG(1)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .rs_a      (rs_a),
    .rs_b      (rs_b),
    .rd        (rd),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_rd    (out_rd),
    .out_flags (out_flags)
  );

  int          checks = 0;
  int          errors = 0;
  exp_t        exp_q[$];
  logic [31:0] mrf[DEPTH];
  bit          rand_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- reference model: sequential register-machine semantics
  function automatic logic [31:0] mread(input logic [2:0] a);
    return (a == 3'd0) ? 32'd0 : mrf[a];
  endfunction

  function automatic exp_t model_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    longint unsigned ua, ub;
    longint sa, sb, st;
    logic [31:0] r;
    logic c, v;
    ua = 64'(a);
    ub = 64'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    c  = 1'b0;
    v  = 1'b0;
    r  = 32'd0;
    st = 0;
    case (op)
      3'd0: begin
        r  = a + b;
        c  = (ua + ub) > 64'hFFFF_FFFF;
        st = sa + sb;
        v  = (st != longint'($signed(r)));
      end
      3'd1: begin
        r  = a - b;
        c  = (a < b);
        st = sa - sb;
        v  = (st != longint'($signed(r)));
      end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
      3'd6: r = a << (b % 32);
      default: r = a >> (b % 32);
    endcase
    e.d  = r;
    e.rd = 3'd0;
    e.f  = {r[31], (r == 32'd0), c, v};
    return e;
  endfunction

  task automatic push_expect(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                             input logic [2:0] rdst, input bit use_exp,
                             input logic [31:0] ed, input logic [3:0] ef);
    exp_t e;
    if (use_exp) begin
      e.d = ed;
      e.f = ef;
    end else begin
      e = model_op(op, mread(ra), mread(rb));
    end
    e.rd = rdst;
    if (rdst != 3'd0) mrf[rdst] = e.d;
    exp_q.push_back(e);
    $display("IN  op=%0d rs_a=%0d rs_b=%0d rd=%0d", op, ra, rb, rdst);
  endtask

  // ---------------- driver tasks (entered and left at posedge+1)
  task automatic issue(input logic [2:0] op, input logic [2:0] ra, input logic [2:0] rb,
                       input logic [2:0] rdst, input bit use_exp,
                       input logic [31:0] ed, input logic [3:0] ef, output int waited);
    bit done;
    done     = 1'b0;
    waited   = 0;
    in_valid = 1'b1;
    alu_op   = op;
    rs_a     = ra;
    rs_b     = rb;
    rd       = rdst;
    while (!done) begin
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (in_ready) begin
        push_expect(op, ra, rb, rdst, use_exp, ed, ef);
        done = 1'b1;
      end
      @(posedge clk);
      #1;
      if (!done) begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("FAIL accept_timeout actual=no_accept required=accept op=%0d", op);
          done = 1'b1;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [2:0] addr, input logic [31:0] data);
    ld_en   = 1'b1;
    ld_addr = addr;
    ld_data = data;
    @(posedge clk);
    #1;
    ld_en = 1'b0;
    if (addr != 3'd0) mrf[addr] = data;
    $display("LD  r%0d=%h", addr, data);
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
  endtask

  // Offer ops for a fixed number of cycles with whatever out_ready is set;
  // returns how many the DUT accepted.
  task automatic offer_fixed(input int cycles, output int acc);
    logic [2:0] ops[3];
    logic [2:0] dsts[3];
    ops[0] = 3'd0; ops[1] = 3'd4; ops[2] = 3'd1;
    dsts[0] = 3'd5; dsts[1] = 3'd6; dsts[2] = 3'd7;
    acc = 0;
    for (int cyc = 0; cyc < cycles; cyc++) begin
      in_valid = (acc < 3);
      if (acc < 3) begin
        alu_op = ops[acc];
        rs_a   = 3'd1;
        rs_b   = 3'd2;
        rd     = dsts[acc];
      end
      @(negedge clk);
      if (in_valid && in_ready) begin
        push_expect(alu_op, rs_a, rs_b, rd, 1'b0, 32'd0, 4'd0);
        acc++;
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
  endtask

  // ---------------- monitor
  exp_t        mon_e;
  logic        hold_prev = 1'b0;
  logic [31:0] hold_d;
  logic [2:0]  hold_rd;
  logic [3:0]  hold_f;

  always @(negedge clk) begin
    if (rst) begin
      hold_prev = 1'b0;
    end else begin
      if (hold_prev) begin
        checks++;
        if (!out_valid || out_data !== hold_d || out_rd !== hold_rd || out_flags !== hold_f) begin
          errors++;
          $display("FAIL hold_stable actual=v%0b/%h/%0d/%b required=v1/%h/%0d/%b",
                   out_valid, out_data, out_rd, out_flags, hold_d, hold_rd, hold_f);
        end
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output actual=%h/%0d/%b required=none", out_data, out_rd, out_flags);
        end else begin
          mon_e = exp_q.pop_front();
          if (out_data !== mon_e.d || out_rd !== mon_e.rd || out_flags !== mon_e.f) begin
            errors++;
            $display("FAIL result actual=%h/rd%0d/%b required=%h/rd%0d/%b",
                     out_data, out_rd, out_flags, mon_e.d, mon_e.rd, mon_e.f);
          end else begin
            $display("OUT data=%h rd=%0d flags=%b", out_data, out_rd, out_flags);
          end
        end
      end
      hold_prev = out_valid && !out_ready;
      hold_d    = out_data;
      hold_rd   = out_rd;
      hold_f    = out_flags;
    end
  end

  // ---------------- stimulus
  int w;
  int acc;

  initial begin
    rst = 1'b1; in_valid = 1'b0; alu_op = 3'd0; rs_a = '0; rs_b = '0; rd = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) mrf[i] = 32'd0;

    // Reset state
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(0));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_rd", 64'(out_rd), 64'(0));
    check("rst_out_flags", 64'(out_flags), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    // Load and add, then read back r3
    load(3'd1, 32'd5);
    load(3'd2, 32'd7);
    issue(3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 32'd12, 4'b0000, w);
    drain();
    issue(3'd0, 3'd3, 3'd0, 3'd5, 1'b1, 32'd12, 4'b0000, w);
    drain();

    // Back-to-back dependency through the bypass
    issue(3'd0, 3'd1, 3'd2, 3'd3, 1'b1, 32'd12, 4'b0000, w);
    issue(3'd1, 3'd3, 3'd1, 3'd4, 1'b1, 32'd7, 4'b0000, w);
    check("b2b_no_stall", 64'(w), 64'(0));
    drain();

    // Flags
    load(3'd1, 32'h7FFF_FFFF);
    load(3'd2, 32'd1);
    load(3'd3, 32'd3);
    load(3'd4, 32'd5);
    load(3'd5, 32'd4);
    load(3'd6, 32'hFFFF_FFFF);
    issue(3'd0, 3'd1, 3'd2, 3'd7, 1'b1, 32'h8000_0000, 4'b1001, w);
    issue(3'd1, 3'd3, 3'd4, 3'd7, 1'b1, 32'hFFFF_FFFE, 4'b1010, w);
    issue(3'd1, 3'd5, 3'd5, 3'd7, 1'b1, 32'd0, 4'b0100, w);
    issue(3'd0, 3'd6, 3'd2, 3'd7, 1'b1, 32'd0, 4'b0110, w);
    drain();

    // Zero register and shifts
    load(3'd0, 32'd9);
    load(3'd1, 32'd1);
    load(3'd2, 32'd31);
    load(3'd5, 32'd32);
    load(3'd6, 32'h1234_5678);
    issue(3'd0, 3'd0, 3'd0, 3'd0, 1'b1, 32'd0, 4'b0100, w);
    issue(3'd0, 3'd0, 3'd0, 3'd7, 1'b1, 32'd0, 4'b0100, w);
    issue(3'd6, 3'd1, 3'd2, 3'd3, 1'b1, 32'h8000_0000, 4'b1000, w);
    issue(3'd7, 3'd6, 3'd5, 3'd3, 1'b1, 32'h1234_5678, 4'b0000, w);
    drain();

    // Backpressure: 3 ops offered over 4 stalled cycles, only 2 fit
    out_ready = 1'b0;
    offer_fixed(4, acc);
    check("bp_accepted", 64'(acc), 64'(2));
    check("bp_in_ready_low", 64'(in_ready), 64'(0));
    out_ready = 1'b1;
    issue(3'd1, 3'd1, 3'd2, 3'd7, 1'b0, 32'd0, 4'd0, w);
    drain();

    // Reset with both stages full; the load during reset must be ignored
    out_ready = 1'b0;
    offer_fixed(3, acc);
    check("rstmid_full", 64'(out_valid), 64'(1));
    rst = 1'b1;
    ld_en = 1'b1; ld_addr = 3'd2; ld_data = 32'h0000_0ABC;
    @(negedge clk);
    check("rstmid_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    ld_en = 1'b0;
    exp_q.delete();
    for (int i = 0; i < DEPTH; i++) mrf[i] = 32'd0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rstmid_out_valid", 64'(out_valid), 64'(0));
    check("rstmid_out_data", 64'(out_data), 64'(0));
    check("rstmid_out_flags", 64'(out_flags), 64'(0));
    @(posedge clk); #1;
    issue(3'd3, 3'd6, 3'd2, 3'd7, 1'b1, 32'd0, 4'b0100, w);
    issue(3'd3, 3'd5, 3'd1, 3'd7, 1'b1, 32'd0, 4'b0100, w);
    drain();

    // Randomised traffic with random backpressure, loads between bursts
    for (int blk = 0; blk < 8; blk++) begin
      rand_ready = 1'b0;
      drain();
      for (int k = 0; k < 3; k++) begin
        logic [31:0] v;
        case ($urandom_range(0, 5))
          0: v = 32'd0;
          1: v = 32'd1;
          2: v = 32'h7FFF_FFFF;
          3: v = 32'h8000_0000;
          4: v = 32'hFFFF_FFFF;
          default: v = $urandom;
        endcase
        load(3'($urandom_range(0, 7)), v);
      end
      rand_ready = 1'b1;
      for (int k = 0; k < 20; k++) begin
        issue(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
              3'($urandom_range(0, 7)), 1'b0, 32'd0, 4'd0, w);
      end
    end
    rand_ready = 1'b0;
    drain();
    check("queue_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
